// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, the
// default payload width and the idle line level.
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_bit_timer.sv
// Bit-period timer: counts clk cycles inside one serial bit and flags the
// last one. A synchronous clear restarts the period on every FSM step.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_last_tick
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] r_tick_cnt;

    assign o_last_tick = (r_tick_cnt == LAST_TICK);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (i_clear) begin
            r_tick_cnt <= '0;
        end else if (!o_last_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: latches a byte, then serialises
// start, LSB-first data, optional parity (from the external parity block), stop.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_bit,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    tx_state_t     r_state;
    logic [BW-1:0] r_bit_cnt;
    logic          r_par_en;
    logic          w_last_tick;
    logic          w_timer_clear;
    logic [BW-1:0] w_next_bit;

    // The timer restarts on every bit boundary and is held clear while idle,
    // so START always begins at tick 0.
    assign w_timer_clear = (r_state == IDLE) || w_last_tick;
    assign w_next_bit    = r_bit_cnt + 1'b1;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk         (clk),
        .rst_n       (rest),
        .i_clear     (w_timer_clear),
        .o_last_tick (w_last_tick)
    );

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_par_en   <= 1'b0;
            frame_data <= '0;
            tx_out     <= IDLE_LEVEL;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    tx_out    <= IDLE_LEVEL;
                    busy      <= 1'b0;
                    r_bit_cnt <= '0;
                    if (data_valid) begin
                        frame_data <= p_data;
                        r_par_en   <= par_en;
                        tx_out     <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= START;
                    end
                end

                START: begin
                    if (w_last_tick) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                        tx_out    <= frame_data[0];
                    end
                end

                DATA: begin
                    if (w_last_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            if (r_par_en) begin
                                // par_bit has long settled from frame_data by now.
                                r_state <= PARITY;
                                tx_out  <= par_bit;
                            end else begin
                                r_state <= STOP;
                                tx_out  <= IDLE_LEVEL;
                            end
                        end else begin
                            r_bit_cnt <= w_next_bit;
                            tx_out    <= frame_data[w_next_bit];
                        end
                    end
                end

                PARITY: begin
                    if (w_last_tick) begin
                        r_state <= STOP;
                        tx_out  <= IDLE_LEVEL;
                    end
                end

                STOP: begin
                    if (w_last_tick) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        tx_out  <= IDLE_LEVEL;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_bit_cnt <= '0;
                    tx_out    <= IDLE_LEVEL;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
